// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch / load-store memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BEAT,
    DONE
  } state_e;

  localparam int BEATS = 4;
  localparam int REQ_I = 0;
  localparam int REQ_D = 1;

  // Big-endian lane select: beat 0 carries bits 31:24.
  function automatic logic [7:0] beatByte(input logic [31:0] word, input logic [1:0] cnt);
    logic [7:0] b;
    case (cnt)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; the last-grant pointer moves only on the update strobe.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       update_i,
  input  logic       upd_idx_i,
  output logic       gnt_valid_o,
  output logic       gnt_idx_o
);

  logic last_q, last_d;

  // On a tie the requester not served last wins; a lone request always wins.
  always_comb begin
    gnt_valid_o = |req_i;
    gnt_idx_o   = 1'(REQ_I);
    if (req_i == 2'b11) begin
      gnt_idx_o = ~last_q;
    end else if (req_i[REQ_D]) begin
      gnt_idx_o = 1'(REQ_D);
    end
  end

  always_comb begin
    last_d = last_q;
    if (update_i) begin
      last_d = upd_idx_i;
    end
  end

  // Pointer starts at the data side so fetch wins the first tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= 1'(REQ_D);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Puts instruction fetch and load/store on one byte-wide memory port, moving
// each 32-bit word as four big-endian byte beats.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MEM_BYTES = 128
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              iReq,
  input  logic [ADDR_W-1:0] iAddr,
  output logic              iAck,
  output logic              iErr,
  output logic [31:0]       iData,
  input  logic              dReq,
  input  logic              dWR,
  input  logic [ADDR_W-1:0] dAddr,
  input  logic [31:0]       dDataIn,
  output logic              dAck,
  output logic              dErr,
  output logic [31:0]       dDataOut,
  output logic [ADDR_W-1:0] mAddr,
  output logic [7:0]        mWData,
  input  logic [7:0]        mRData,
  output logic              mRD,
  output logic              mWR
);

  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_q, wr_d;
  logic              err_q, err_d;
  logic              gnt_q, gnt_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [23:0]       asm_q, asm_d;
  logic [31:0]       iData_q, iData_d;
  logic [31:0]       dData_q, dData_d;

  logic              gntValid, gntIdx;
  logic [ADDR_W-1:0] selAddr;
  logic [ADDR_W:0]   endAddr;
  logic              selErr;

  rr_arb2 u_arb (
    .clk_i       (clk),
    .rst_ni      (RST),
    .req_i       ({dReq, iReq}),
    .update_i    (state_q == DONE),
    .upd_idx_i   (gnt_q),
    .gnt_valid_o (gntValid),
    .gnt_idx_o   (gntIdx)
  );

  // One extra bit on the end address keeps the range check free of wrap-around.
  assign selAddr = gntIdx ? dAddr : iAddr;
  assign endAddr = {1'b0, selAddr} + (ADDR_W+1)'(3);
  assign selErr  = (selAddr[1:0] != 2'b00) || (endAddr >= MEM_LIMIT);

  assign iData    = iData_q;
  assign dDataOut = dData_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    err_d   = err_q;
    gnt_d   = gnt_q;
    wdata_d = wdata_q;
    asm_d   = asm_q;
    iData_d = iData_q;
    dData_d = dData_q;
    iAck    = 1'b0;
    iErr    = 1'b0;
    dAck    = 1'b0;
    dErr    = 1'b0;
    mAddr   = '0;
    mWData  = 8'h00;
    mRD     = 1'b0;
    mWR     = 1'b0;

    case (state_q)
      IDLE: begin
        if (gntValid) begin
          gnt_d   = gntIdx;
          addr_d  = selAddr;
          wr_d    = gntIdx ? dWR : 1'b0;
          wdata_d = gntIdx ? dDataIn : 32'h0;
          err_d   = selErr;
          cnt_d   = 2'd0;
          state_d = selErr ? DONE : BEAT;
        end
      end

      BEAT: begin
        mAddr = addr_q + {{(ADDR_W-2){1'b0}}, cnt_q};
        if (wr_q) begin
          mWR    = 1'b1;
          mWData = beatByte(wdata_q, cnt_q);
        end else begin
          mRD = 1'b1;
          // The last byte goes straight into the requester's output register
          // so the word is already visible in the ack cycle.
          case (cnt_q)
            2'd0: asm_d[23:16] = mRData;
            2'd1: asm_d[15:8]  = mRData;
            2'd2: asm_d[7:0]   = mRData;
            default: begin
              if (gnt_q == 1'(REQ_D)) begin
                dData_d = {asm_q, mRData};
              end else begin
                iData_d = {asm_q, mRData};
              end
            end
          endcase
        end
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'(BEATS-1)) begin
          state_d = DONE;
        end
      end

      DONE: begin
        if (gnt_q == 1'(REQ_D)) begin
          dAck = 1'b1;
          dErr = err_q;
        end else begin
          iAck = 1'b1;
          iErr = err_q;
        end
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // Reset aborts any access in flight; bytes already written are not undone.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      gnt_q   <= 1'b0;
      wdata_q <= 32'h0;
      asm_q   <= 24'h0;
      iData_q <= 32'h0;
      dData_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      gnt_q   <= gnt_d;
      wdata_q <= wdata_d;
      asm_q   <= asm_d;
      iData_q <= iData_d;
      dData_q <= dData_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte-array memory model on the shared port.
module tb_mem_arbiter;

  localparam int ADDR_W    = 32;
  localparam int MEM_BYTES = 128;

  logic              clk = 1'b0;
  logic              RST = 1'b1;
  logic              iReq = 1'b0;
  logic [ADDR_W-1:0] iAddr = '0;
  logic              iAck, iErr;
  logic [31:0]       iData;
  logic              dReq = 1'b0;
  logic              dWR = 1'b0;
  logic [ADDR_W-1:0] dAddr = '0;
  logic [31:0]       dDataIn = '0;
  logic              dAck, dErr;
  logic [31:0]       dDataOut;
  logic [ADDR_W-1:0] mAddr;
  logic [7:0]        mWData;
  logic [7:0]        mRData;
  logic              mRD, mWR;

  int compared = 0;
  int mismatched = 0;

  logic [7:0] mem [0:MEM_BYTES-1];

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .RST(RST),
    .iReq(iReq), .iAddr(iAddr), .iAck(iAck), .iErr(iErr), .iData(iData),
    .dReq(dReq), .dWR(dWR), .dAddr(dAddr), .dDataIn(dDataIn),
    .dAck(dAck), .dErr(dErr), .dDataOut(dDataOut),
    .mAddr(mAddr), .mWData(mWData), .mRData(mRData), .mRD(mRD), .mWR(mWR)
  );

  always @(posedge clk) if (mWR) mem[mAddr[6:0]] = mWData;
  assign mRData = mRD ? mem[mAddr[6:0]] : 8'h00;

  // Requester inputs must stay stable while a request waits for its ack.
  logic pI = 1'b0, pIAck = 1'b0, pD = 1'b0, pDAck = 1'b0, pDWR = 1'b0;
  logic [ADDR_W-1:0] pIAddr = '0, pDAddr = '0;
  logic [31:0] pDData = '0;
  always @(posedge clk) begin
    if (RST && pI && !pIAck && iReq)
      assert (iAddr == pIAddr) else begin
        mismatched++;
        $display("[TB] FAIL iStable iAddr changed %h -> %h while pending", pIAddr, iAddr);
      end
    if (RST && pD && !pDAck && dReq)
      assert (dAddr == pDAddr && dWR == pDWR && dDataIn == pDData) else begin
        mismatched++;
        $display("[TB] FAIL dStable data-side inputs changed while pending");
      end
    pI <= iReq; pIAck <= iAck; pIAddr <= iAddr;
    pD <= dReq; pDAck <= dAck; pDAddr <= dAddr; pDWR <= dWR; pDData <= dDataIn;
  end

  task automatic waitAck(input bit isD, input int limit, output int cyc);
    cyc = -1;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clk);
      if ((isD ? dAck : iAck) === 1'b1) begin
        cyc = k;
        return;
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (2) @(negedge clk);
    compared++;
    if ({iAck, iErr, dAck, dErr, mRD, mWR} !== 6'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_flags got %b want 000000", {iAck, iErr, dAck, dErr, mRD, mWR});
    end
    compared++;
    if ({iData, dDataOut, mAddr, mWData} !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_data got iData=%h dDataOut=%h mAddr=%h mWData=%h want all 0",
               iData, dDataOut, mAddr, mWData);
    end
    RST = 1'b1;
    @(negedge clk);
    compared++;
    if ({iAck, dAck, mRD, mWR} !== 4'b0) begin
      mismatched++;
      $display("[TB] FAIL idle_quiet got %b want 0000", {iAck, dAck, mRD, mWR});
    end
  endtask

  task automatic test_load();
    int cyc;
    mem[8'h10] = 8'h12; mem[8'h11] = 8'h34; mem[8'h12] = 8'h56; mem[8'h13] = 8'h78;
    dReq = 1'b1; dWR = 1'b0; dAddr = 32'h10; dDataIn = 32'h0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      compared++;
      if (mAddr !== 32'(16 + k - 1) || mRD !== 1'b1 || mWR !== 1'b0 || dAck !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL load_beat%0d got mAddr=%h mRD=%b mWR=%b dAck=%b want mAddr=%h mRD=1 mWR=0 dAck=0",
                 k - 1, mAddr, mRD, mWR, dAck, 32'(16 + k - 1));
      end
    end
    waitAck(1'b1, 1, cyc);
    compared++;
    if (cyc !== 1 || dErr !== 1'b0 || dDataOut !== 32'h12345678 || iAck !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL load_ack got ack=%0d dErr=%b dDataOut=%h iAck=%b want ack=1 dErr=0 dDataOut=12345678 iAck=0",
               cyc, dErr, dDataOut, iAck);
    end
    dReq = 1'b0;
    @(negedge clk);
    compared++;
    if (dAck !== 1'b0 || mRD !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL load_ack_pulse got dAck=%b mRD=%b want 0 0", dAck, mRD);
    end
  endtask

  task automatic test_store();
    int cyc;
    logic [7:0] expB [4];
    expB = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    dReq = 1'b1; dWR = 1'b1; dAddr = 32'h20; dDataIn = 32'hDEADBEEF;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      compared++;
      if (mWR !== 1'b1 || mRD !== 1'b0 || mWData !== expB[k] || mAddr !== 32'(32 + k)) begin
        mismatched++;
        $display("[TB] FAIL store_beat%0d got mWR=%b mRD=%b mWData=%h mAddr=%h want mWR=1 mRD=0 mWData=%h mAddr=%h",
                 k, mWR, mRD, mWData, mAddr, expB[k], 32'(32 + k));
      end
    end
    waitAck(1'b1, 1, cyc);
    compared++;
    if (cyc !== 1 || dErr !== 1'b0 || dDataOut !== 32'h12345678) begin
      mismatched++;
      $display("[TB] FAIL store_ack got ack=%0d dErr=%b dDataOut=%h want ack=1 dErr=0 dDataOut=12345678",
               cyc, dErr, dDataOut);
    end
    dReq = 1'b0; dWR = 1'b0;
    @(negedge clk);
    iReq = 1'b1; iAddr = 32'h20;
    waitAck(1'b0, 10, cyc);
    compared++;
    if (cyc !== 5 || iErr !== 1'b0 || iData !== 32'hDEADBEEF) begin
      mismatched++;
      $display("[TB] FAIL fetch_after_store got ack=%0d iErr=%b iData=%h want ack=5 iErr=0 iData=deadbeef",
               cyc, iErr, iData);
    end
    iReq = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_store();
    bit bad;
    mem[8'h30] = 8'h11; mem[8'h31] = 8'h22; mem[8'h32] = 8'h33; mem[8'h33] = 8'h44;
    dReq = 1'b1; dWR = 1'b1; dAddr = 32'h30; dDataIn = 32'hA1B2C3D4;
    repeat (3) @(negedge clk);
    compared++;
    if (mWR !== 1'b1 || mAddr !== 32'h32) begin
      mismatched++;
      $display("[TB] FAIL midstore_at_beat2 got mWR=%b mAddr=%h want 1 00000032", mWR, mAddr);
    end
    RST = 1'b0;
    dReq = 1'b0; dWR = 1'b0;
    #1;
    compared++;
    if ({iAck, iErr, dAck, dErr, mRD, mWR} !== 6'b0 || {iData, dDataOut, mAddr, mWData} !== '0) begin
      mismatched++;
      $display("[TB] FAIL midstore_reset_outputs got flags=%b iData=%h dDataOut=%h mAddr=%h mWData=%h want all 0",
               {iAck, iErr, dAck, dErr, mRD, mWR}, iData, dDataOut, mAddr, mWData);
    end
    @(negedge clk);
    RST = 1'b1;
    compared++;
    if ({mem[8'h30], mem[8'h31], mem[8'h32], mem[8'h33]} !== 32'hA1B23344) begin
      mismatched++;
      $display("[TB] FAIL midstore_memory got %h want a1b23344",
               {mem[8'h30], mem[8'h31], mem[8'h32], mem[8'h33]});
    end
    bad = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (iAck !== 1'b0 || dAck !== 1'b0 || mWR !== 1'b0 || mRD !== 1'b0) bad = 1'b1;
    end
    compared++;
    if (bad) begin
      mismatched++;
      $display("[TB] FAIL midstore_no_ack got activity=1 want 0");
    end
  endtask

  task automatic test_errors();
    int cyc;
    iReq = 1'b1; iAddr = 32'h02;
    @(negedge clk);
    compared++;
    if ({iAck, iErr} !== 2'b11 || {mRD, mWR} !== 2'b00 || iData !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL misaligned_fetch got iAck=%b iErr=%b mRD=%b mWR=%b iData=%h want 1 1 0 0 0",
               iAck, iErr, mRD, mWR, iData);
    end
    iReq = 1'b0;
    @(negedge clk);
    compared++;
    if (iAck !== 1'b0 || iErr !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL err_ack_pulse got iAck=%b iErr=%b want 0 0", iAck, iErr);
    end
    mem[8'h7C] = 8'hCA; mem[8'h7D] = 8'hFE; mem[8'h7E] = 8'hF0; mem[8'h7F] = 8'h0D;
    dReq = 1'b1; dWR = 1'b1; dAddr = 32'h7E; dDataIn = 32'hFFFFFFFF;
    @(negedge clk);
    compared++;
    if ({dAck, dErr} !== 2'b11 || mWR !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL range_store got dAck=%b dErr=%b mWR=%b want 1 1 0", dAck, dErr, mWR);
    end
    dReq = 1'b0; dWR = 1'b0;
    @(negedge clk);
    dReq = 1'b1; dAddr = 32'h7C;
    waitAck(1'b1, 10, cyc);
    compared++;
    if (cyc !== 5 || dErr !== 1'b0 || dDataOut !== 32'hCAFEF00D) begin
      mismatched++;
      $display("[TB] FAIL last_word_load got ack=%0d dErr=%b dDataOut=%h want ack=5 dErr=0 dDataOut=cafef00d",
               cyc, dErr, dDataOut);
    end
    dReq = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] expW [3];
    int ackT [3];
    int n, lastAck;
    expW = '{32'h01020304, 32'h05060708, 32'h090A0B0C};
    for (int b = 0; b < 12; b++) mem[b] = 8'(b + 1);
    n = 0; lastAck = -10;
    ackT = '{-1, -1, -1};
    iReq = 1'b1; iAddr = 32'h0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == lastAck + 1 && n < 3) iAddr = 32'(4 * n);
      if (iAck === 1'b1) begin
        compared++;
        if (n > 2 || iData !== expW[n] || iErr !== 1'b0) begin
          mismatched++;
          $display("[TB] FAIL b2b_data%0d got iData=%h iErr=%b want %h 0", n, iData, iErr,
                   (n > 2) ? 32'h0 : expW[n]);
        end
        if (n < 3) ackT[n] = k;
        n++;
        lastAck = k;
        if (n == 3) iReq = 1'b0;
      end
    end
    compared++;
    if (n !== 3 || ackT[0] !== 5 || ackT[1] !== 11 || ackT[2] !== 17) begin
      mismatched++;
      $display("[TB] FAIL b2b_timing got acks=%0d at %0d,%0d,%0d want 3 at 5,11,17",
               n, ackT[0], ackT[1], ackT[2]);
    end
    iReq = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_contention();
    int ackT [4];
    bit ackWho [4];
    int n;
    bit both;
    n = 0; both = 1'b0;
    ackT = '{-1, -1, -1, -1};
    ackWho = '{1'b0, 1'b0, 1'b0, 1'b0};
    RST = 1'b0;
    iReq = 1'b1; iAddr = 32'h20;
    dReq = 1'b1; dWR = 1'b0; dAddr = 32'h10; dDataIn = 32'h0;
    @(negedge clk);
    RST = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (iAck === 1'b1 && dAck === 1'b1) both = 1'b1;
      if ((iAck === 1'b1 || dAck === 1'b1) && n < 4) begin
        ackT[n] = k;
        ackWho[n] = dAck;
        compared++;
        if ((dAck === 1'b1 && dDataOut !== 32'h12345678) || (iAck === 1'b1 && iData !== 32'hDEADBEEF)) begin
          mismatched++;
          $display("[TB] FAIL contention_data%0d got iData=%h dDataOut=%h want deadbeef / 12345678",
                   n, iData, dDataOut);
        end
        n++;
      end
    end
    compared++;
    if (both || n !== 4) begin
      mismatched++;
      $display("[TB] FAIL contention_count got acks=%0d overlap=%b want 4 0", n, both);
    end
    compared++;
    if (ackWho[0] !== 1'b0 || ackWho[1] !== 1'b1 || ackWho[2] !== 1'b0 || ackWho[3] !== 1'b1 ||
        ackT[0] !== 5 || ackT[1] !== 11 || ackT[2] !== 17 || ackT[3] !== 23) begin
      mismatched++;
      $display("[TB] FAIL contention_order got %0d%0d%0d%0d at %0d,%0d,%0d,%0d want 0101 (0=I) at 5,11,17,23",
               ackWho[0], ackWho[1], ackWho[2], ackWho[3], ackT[0], ackT[1], ackT[2], ackT[3]);
    end
    iReq = 1'b0; dReq = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    for (int b = 0; b < MEM_BYTES; b++) mem[b] = 8'h00;
    $display("[TB] mem_arbiter directed tests starting");
    test_reset();
    test_load();
    test_store();
    test_reset_mid_store();
    test_errors();
    test_back_to_back();
    test_contention();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
